// File: rtl/nmr_pkg.sv
// rtl/nmr_pkg.sv - shared state encoding and default widths for the NMR scan sequencer
package nmr_pkg;

    localparam int SCAN_WIDTH_DEF  = 16;
    localparam int DELAY_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_REPDLY    = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

endpackage

// File: rtl/nmr_scan_sequencer_if.sv
// rtl/nmr_scan_sequencer_if.sv - run-control and pulse-program handshake bundle of the scan sequencer
interface nmr_scan_sequencer_if
    import nmr_pkg::*;
#(
    parameter int SCAN_WIDTH  = SCAN_WIDTH_DEF,
    parameter int DELAY_WIDTH = DELAY_WIDTH_DEF
);
    logic                   START;
    logic                   ABORT;
    logic [SCAN_WIDTH-1:0]  NUM_SCANS;
    logic [DELAY_WIDTH-1:0] REP_DELAY;
    logic                   PHASE_CYC_EN;
    logic [DELAY_WIDTH-1:0] WDT_LIMIT;
    logic                   PP_FSMSTAT;
    logic                   PP_START;
    logic                   PP_PHASE_CYC;
    logic                   BUSY;
    logic [SCAN_WIDTH-1:0]  SCAN_CNT;
    logic                   DONE;
    logic                   ERR;

    modport master (
        output START, ABORT, NUM_SCANS, REP_DELAY, PHASE_CYC_EN, WDT_LIMIT, PP_FSMSTAT,
        input  PP_START, PP_PHASE_CYC, BUSY, SCAN_CNT, DONE, ERR
    );

    modport slave (
        input  START, ABORT, NUM_SCANS, REP_DELAY, PHASE_CYC_EN, WDT_LIMIT, PP_FSMSTAT,
        output PP_START, PP_PHASE_CYC, BUSY, SCAN_CNT, DONE, ERR
    );

endinterface

// File: rtl/nmr_down_counter.sv
// rtl/nmr_down_counter.sv - loadable down counter that stops at zero and flags it
module nmr_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/nmr_scan_sequencer.sv
// rtl/nmr_scan_sequencer.sv - multi-scan run sequencer driving a pulse program; NMR_SCAN_WDT_EN adds a per-scan watchdog
module nmr_scan_sequencer
    import nmr_pkg::*;
#(
    parameter int SCAN_WIDTH  = SCAN_WIDTH_DEF,
    parameter int DELAY_WIDTH = DELAY_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    nmr_scan_sequencer_if.slave  bus
);
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_start_pend;
    logic [SCAN_WIDTH-1:0]  r_num_scans;
    logic [SCAN_WIDTH-1:0]  r_scan_cnt;
    logic [DELAY_WIDTH-1:0] r_rep_delay;
    logic                   r_phase_en;
    logic                   r_phase;
    logic                   r_abort_pend;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_inc;
    logic                   w_phase_tgl;
    logic                   w_dly_load;
    logic                   w_dly_zero;
    logic                   w_wdt_hit;
    logic [DELAY_WIDTH-1:0] w_dly_val;

    // START is registered first so the run decision uses the latched parameters
    assign w_accept  = (r_state == ST_IDLE) && !r_start_pend && bus.START;
    assign w_last    = (r_scan_cnt == r_num_scans);
    assign w_dly_val = (r_rep_delay == '0) ? '0 : r_rep_delay - 1'b1;

    nmr_down_counter #(.WIDTH(DELAY_WIDTH)) u_dly_cnt (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_load     (w_dly_load),
        .i_en       (r_state == ST_REPDLY),
        .i_load_val (w_dly_val),
        .o_zero     (w_dly_zero)
    );

`ifdef NMR_SCAN_WDT_EN
    logic [DELAY_WIDTH-1:0] r_wdt_limit;
    logic                   r_err;
    logic                   w_wdt_zero;
    logic                   w_err_set;

    nmr_down_counter #(.WIDTH(DELAY_WIDTH)) u_wdt_cnt (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_load     (r_state == ST_ARM),
        .i_en       ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)),
        .i_load_val ((r_wdt_limit == '0) ? '0 : r_wdt_limit - 1'b1),
        .o_zero     (w_wdt_zero)
    );

    assign w_wdt_hit = (r_wdt_limit != '0) && w_wdt_zero;
    assign w_err_set = w_wdt_hit &&
                       (((r_state == ST_WAIT_BUSY) && !bus.ABORT) ||
                        ((r_state == ST_WAIT_DONE) && bus.PP_FSMSTAT));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wdt_limit <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_wdt_limit <= bus.WDT_LIMIT;
            r_err       <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign bus.ERR = r_err;
`else
    assign w_wdt_hit = 1'b0;
    assign bus.ERR   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_inc       = 1'b0;
        w_phase_tgl = 1'b0;
        w_dly_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_start_pend) begin
                    w_next = (r_num_scans == '0) ? ST_FINISH : ST_ARM;
                end
            end
            ST_ARM: begin
                w_next = bus.ABORT ? ST_FINISH : ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.ABORT || w_wdt_hit) begin
                    w_next = ST_FINISH;
                end else if (bus.PP_FSMSTAT) begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // an abort here still lets the running pulse program finish its scan
                if (!bus.PP_FSMSTAT) begin
                    if (r_abort_pend || bus.ABORT) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_next     = ST_REPDLY;
                        w_inc      = 1'b1;
                        w_dly_load = 1'b1;
                    end
                end else if (w_wdt_hit) begin
                    w_next = ST_FINISH;
                end
            end
            ST_REPDLY: begin
                if (w_last || bus.ABORT) begin
                    w_next = ST_FINISH;
                end else if (w_dly_zero) begin
                    w_next      = ST_ARM;
                    w_phase_tgl = r_phase_en;
                end
            end
            ST_FINISH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_start_pend <= 1'b0;
            r_num_scans  <= '0;
            r_rep_delay  <= '0;
            r_phase_en   <= 1'b0;
            r_scan_cnt   <= '0;
            r_phase      <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_start_pend <= w_accept;
            if (w_accept) begin
                r_num_scans  <= bus.NUM_SCANS;
                r_rep_delay  <= bus.REP_DELAY;
                r_phase_en   <= bus.PHASE_CYC_EN;
                r_scan_cnt   <= '0;
                r_phase      <= 1'b0;
                r_abort_pend <= 1'b0;
            end else begin
                if (w_inc) begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                end
                if (w_phase_tgl) begin
                    r_phase <= ~r_phase;
                end
                if ((r_state == ST_WAIT_DONE) && bus.ABORT) begin
                    r_abort_pend <= 1'b1;
                end else if (r_state == ST_FINISH) begin
                    r_abort_pend <= 1'b0;
                end
            end
        end
    end

    assign bus.PP_START     = (r_state == ST_ARM);
    assign bus.PP_PHASE_CYC = r_phase;
    assign bus.BUSY         = (r_state != ST_IDLE);
    assign bus.DONE         = (r_state == ST_FINISH);
    assign bus.SCAN_CNT     = r_scan_cnt;

endmodule
